// File: rtl/tty_ctrl_if.sv
// Character, engine-handshake and VRAM port bundle for the teletype sequencer.
// The sequencer binds to the slave modport; the surrounding system uses master.
interface tty_ctrl_if;
  logic        i_valid;
  logic [7:0]  i_char;
  logic        i_ctrl_en;
  logic        o_ready;
  logic        o_scroll_start;
  logic        i_scroll_running;
  logic        o_clear_start;
  logic        i_clear_running;
  logic [10:0] o_vram_addr;
  logic [7:0]  o_vram_din;
  logic        o_vram_ce;
  logic        o_vram_w;
  logic [5:0]  o_col;
  logic [4:0]  o_row;

  modport slave (
    input  i_valid, i_char, i_ctrl_en, i_scroll_running, i_clear_running,
    output o_ready, o_scroll_start, o_clear_start,
    output o_vram_addr, o_vram_din, o_vram_ce, o_vram_w, o_col, o_row
  );

  modport master (
    output i_valid, i_char, i_ctrl_en, i_scroll_running, i_clear_running,
    input  o_ready, o_scroll_start, o_clear_start,
    input  o_vram_addr, o_vram_din, o_vram_ce, o_vram_w, o_col, o_row
  );
endinterface

// File: rtl/tty_ctrl.sv
// Teletype sequencer: decodes one character at a time, writes glyphs at the
// cursor and hands the VRAM port to the scroll/clear engines when they run.
module tty_ctrl #(
  parameter int COLS = 60,
  parameter int ROWS = 17
) (
  input  logic      i_clk,
  input  logic      i_rst,
  tty_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    DECODE,
    WRITE,
    ADV,
    SCR_START,
    SCR_WAIT_HI,
    SCR_WAIT_LO,
    CLR_START,
    CLR_WAIT_HI,
    CLR_WAIT_LO
  } state_t;

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_DEL = 8'h7F;

  state_t     state;
  state_t     state_next;
  logic [5:0] col;
  logic [5:0] col_next;
  logic [4:0] row;
  logic [4:0] row_next;
  logic [7:0] char_q;
  logic       ctrl_q;
  logic       newline;
  logic       engine_busy;
  logic       accept;

  assign engine_busy = bus.i_scroll_running | bus.i_clear_running;
  assign accept      = bus.i_valid & bus.o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col    <= '0;
      row    <= '0;
      char_q <= '0;
      ctrl_q <= 1'b0;
    end else begin
      col <= col_next;
      row <= row_next;
      if (accept) begin
        char_q <= bus.i_char;
        ctrl_q <= bus.i_ctrl_en;
      end
    end
  end

  // Newline is requested from both DECODE (LF) and ADV (line wrap) and
  // resolved once after the case so both paths share the scroll decision.
  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    newline    = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) state_next = DECODE;
      end

      DECODE: begin
        if (!ctrl_q) begin
          state_next = WRITE;
        end else begin
          unique case (char_q)
            CH_CR: begin
              col_next   = '0;
              state_next = IDLE;
            end
            CH_LF: begin
              newline = 1'b1;
            end
            CH_BS: begin
              if (col != '0) col_next = col - 6'd1;
              state_next = IDLE;
            end
            CH_FF: begin
              col_next   = '0;
              row_next   = '0;
              state_next = CLR_START;
            end
            default: begin
              if (char_q < CH_SP || char_q == CH_DEL) begin
                state_next = IDLE;
              end else begin
                state_next = WRITE;
              end
            end
          endcase
        end
      end

      WRITE: begin
        state_next = ADV;
      end

      ADV: begin
        if (col < LAST_COL) begin
          col_next   = col + 6'd1;
          state_next = IDLE;
        end else begin
          col_next = '0;
          newline  = 1'b1;
        end
      end

      SCR_START:   state_next = SCR_WAIT_HI;
      SCR_WAIT_HI: if (bus.i_scroll_running)  state_next = SCR_WAIT_LO;
      SCR_WAIT_LO: if (!bus.i_scroll_running) state_next = IDLE;

      CLR_START:   state_next = CLR_WAIT_HI;
      CLR_WAIT_HI: if (bus.i_clear_running)   state_next = CLR_WAIT_LO;
      CLR_WAIT_LO: if (!bus.i_clear_running)  state_next = IDLE;

      default: state_next = IDLE;
    endcase

    // On the bottom row the row stays put and the scroll engine makes room.
    if (newline) begin
      if (row < LAST_ROW) begin
        row_next   = row + 5'd1;
        state_next = IDLE;
      end else begin
        state_next = SCR_START;
      end
    end
  end

  assign bus.o_ready        = (state == IDLE) && !engine_busy;
  assign bus.o_scroll_start = (state == SCR_START);
  assign bus.o_clear_start  = (state == CLR_START);
  assign bus.o_vram_ce      = (state == WRITE);
  assign bus.o_vram_w       = (state == WRITE);
  assign bus.o_vram_din     = (state == WRITE) ? char_q : 8'h00;
  assign bus.o_vram_addr    = {row, col};
  assign bus.o_col          = col;
  assign bus.o_row          = row;

  cursor_col_in_range: assert property (@(posedge i_clk) disable iff (i_rst)
    col <= LAST_COL);
  cursor_row_in_range: assert property (@(posedge i_clk) disable iff (i_rst)
    row <= LAST_ROW);
  starts_exclusive: assert property (@(posedge i_clk) disable iff (i_rst)
    !(bus.o_scroll_start && bus.o_clear_start));

endmodule

// File: tb/tb_tty_ctrl.sv
// Directed bench for tty_ctrl: expected VRAM writes go into a scoreboard queue
// and a negedge monitor pops them; scroll/clear engines are simple models.
module tb_tty_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tty_ctrl_if bus ();

  tty_ctrl #(.COLS(60), .ROWS(17)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  din;
    int          cyc;
  } wr_t;

  wr_t expQ[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;
  int  scrPulses  = 0;
  int  clrPulses  = 0;
  int  scrLen     = 20;
  int  clrLen     = 100;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine models: running rises the cycle after the start pulse and stays
  // high for the programmed length; reset shares the sequencer's reset.
  initial begin
    int   cnt;
    logic st;
    logic rs;
    cnt = 0;
    bus.i_scroll_running = 1'b0;
    forever begin
      @(negedge clk);
      st = bus.o_scroll_start;
      @(posedge clk);
      rs = rst;
      #2;
      if (rs) begin
        cnt = 0;
        bus.i_scroll_running = 1'b0;
      end else if (st) begin
        cnt = scrLen;
        bus.i_scroll_running = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.i_scroll_running = 1'b0;
      end
    end
  end

  initial begin
    int   cnt;
    logic st;
    logic rs;
    cnt = 0;
    bus.i_clear_running = 1'b0;
    forever begin
      @(negedge clk);
      st = bus.o_clear_start;
      @(posedge clk);
      rs = rst;
      #2;
      if (rs) begin
        cnt = 0;
        bus.i_clear_running = 1'b0;
      end else if (st) begin
        cnt = clrLen;
        bus.i_clear_running = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.i_clear_running = 1'b0;
      end
    end
  end

  // Monitor: every VRAM strobe must match the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.o_scroll_start) scrPulses++;
        if (bus.o_clear_start)  clrPulses++;
        if (bus.o_vram_ce || bus.o_vram_w) begin
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_write: got addr=%0h din=%0h at cycle %0d, required no write",
                     bus.o_vram_addr, bus.o_vram_din, cyc);
          end else begin
            e = expQ.pop_front();
            checkOutput("write_addr",  32'(bus.o_vram_addr), 32'(e.addr));
            checkOutput("write_din",   32'(bus.o_vram_din),  32'(e.din));
            checkOutput("write_cycle", cyc,                  e.cyc);
            checkOutput("write_ce",    32'(bus.o_vram_ce),   32'd1);
            checkOutput("write_w",     32'(bus.o_vram_w),    32'd1);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] c, input logic ctrl, input bit expWr,
                               input logic [10:0] expAddr, output int tAcc);
    int waited;
    waited = 0;
    tAcc   = -1;
    @(negedge clk);
    while (!bus.o_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.o_ready) begin
      checkOutput("accept_timeout_ready", 32'(bus.o_ready), 32'd1);
      return;
    end
    bus.i_valid   = 1'b1;
    bus.i_char    = c;
    bus.i_ctrl_en = ctrl;
    tAcc          = cyc;
    if (expWr) expQ.push_back('{expAddr, c, cyc + 2});
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic waitReady(output int rc);
    int n;
    n  = 0;
    rc = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_ready && n < 500);
    if (bus.o_ready) rc = cyc;
    else checkOutput("ready_timeout", 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    int t;
    int r;
    int sPrev;
    int cPrev;

    #500000;
    $display("[TB] FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int r;
    int sPrev;
    int cPrev;

    rst           = 1'b1;
    bus.i_valid   = 1'b0;
    bus.i_char    = 8'h00;
    bus.i_ctrl_en = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready",        32'(bus.o_ready),        32'd1);
    checkOutput("rst_col",          32'(bus.o_col),          32'd0);
    checkOutput("rst_row",          32'(bus.o_row),          32'd0);
    checkOutput("rst_vram_ce",      32'(bus.o_vram_ce),      32'd0);
    checkOutput("rst_vram_w",       32'(bus.o_vram_w),       32'd0);
    checkOutput("rst_vram_din",     32'(bus.o_vram_din),     32'd0);
    checkOutput("rst_scroll_start", 32'(bus.o_scroll_start), 32'd0);
    checkOutput("rst_clear_start",  32'(bus.o_clear_start),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single printable: write at T+2, ready again at T+4.
    applyStimulus(8'h41, 1'b1, 1'b1, 11'h000, t);
    waitReady(r);
    checkOutput("A_ready_latency", r - t, 32'd4);
    checkOutput("A_col", 32'(bus.o_col), 32'd1);
    checkOutput("A_row", 32'(bus.o_row), 32'd0);

    applyStimulus(8'h0D, 1'b1, 1'b0, 11'h000, t);
    waitReady(r);
    checkOutput("CR_ready_latency", r - t, 32'd2);
    checkOutput("CR_col", 32'(bus.o_col), 32'd0);

    // A full line wraps to the next row without scrolling.
    for (int i = 0; i < 60; i++) applyStimulus(8'h78, 1'b1, 1'b1, {5'd0, 6'(i)}, t);
    waitReady(r);
    checkOutput("line_col", 32'(bus.o_col), 32'd0);
    checkOutput("line_row", 32'(bus.o_row), 32'd1);
    checkOutput("line_scroll_pulses", scrPulses, 32'd0);

    for (int i = 0; i < 15; i++) applyStimulus(8'h0A, 1'b1, 1'b0, 11'h000, t);
    waitReady(r);
    checkOutput("LF_ready_latency", r - t, 32'd2);
    checkOutput("LF_row", 32'(bus.o_row), 32'd16);

    for (int i = 0; i < 59; i++) applyStimulus(8'h79, 1'b1, 1'b1, {5'd16, 6'(i)}, t);
    waitReady(r);
    checkOutput("pre_wrap_col", 32'(bus.o_col), 32'd59);

    // Bottom-right glyph: write at T+2, scroll start at T+4, running T+5..T+24.
    sPrev = scrPulses;
    applyStimulus(8'h5A, 1'b1, 1'b1, {5'd16, 6'd59}, t);
    waitReady(r);
    checkOutput("wrap_ready_latency", r - t, 32'd26);
    checkOutput("wrap_scroll_pulses", scrPulses - sPrev, 32'd1);
    checkOutput("wrap_col", 32'(bus.o_col), 32'd0);
    checkOutput("wrap_row", 32'(bus.o_row), 32'd16);

    // Form feed: clear start at T+2, running T+3..T+102, ready at T+104.
    cPrev = clrPulses;
    applyStimulus(8'h0C, 1'b1, 1'b0, 11'h000, t);
    waitReady(r);
    checkOutput("FF_ready_latency", r - t, 32'd104);
    checkOutput("FF_clear_pulses", clrPulses - cPrev, 32'd1);
    checkOutput("FF_col", 32'(bus.o_col), 32'd0);
    checkOutput("FF_row", 32'(bus.o_row), 32'd0);

    applyStimulus(8'h0D, 1'b1, 1'b0, 11'h000, t);
    waitReady(r);
    checkOutput("CR2_col", 32'(bus.o_col), 32'd0);
    applyStimulus(8'h08, 1'b1, 1'b0, 11'h000, t);
    waitReady(r);
    checkOutput("BS_at_0_col", 32'(bus.o_col), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(8'h71, 1'b1, 1'b1, {5'd0, 6'(i)}, t);
    applyStimulus(8'h08, 1'b1, 1'b0, 11'h000, t);
    waitReady(r);
    checkOutput("BS_ready_latency", r - t, 32'd2);
    checkOutput("BS_at_5_col", 32'(bus.o_col), 32'd4);
    applyStimulus(8'h07, 1'b1, 1'b0, 11'h000, t);
    waitReady(r);
    checkOutput("BEL_ready_latency", r - t, 32'd2);
    checkOutput("BEL_col", 32'(bus.o_col), 32'd4);
    applyStimulus(8'h7F, 1'b1, 1'b0, 11'h000, t);
    waitReady(r);
    checkOutput("DEL_col", 32'(bus.o_col), 32'd4);
    applyStimulus(8'h07, 1'b0, 1'b1, {5'd0, 6'd4}, t);
    waitReady(r);
    checkOutput("raw_BEL_ready_latency", r - t, 32'd4);
    checkOutput("raw_BEL_col", 32'(bus.o_col), 32'd5);

    // Reset while waiting for the scroll engine to finish.
    scrLen = 50;
    for (int i = 0; i < 16; i++) applyStimulus(8'h0A, 1'b1, 1'b0, 11'h000, t);
    waitReady(r);
    checkOutput("pre_rst_row", 32'(bus.o_row), 32'd16);
    sPrev = scrPulses;
    applyStimulus(8'h0A, 1'b1, 1'b0, 11'h000, t);
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("wait_lo_ready", 32'(bus.o_ready), 32'd0);
    checkOutput("wait_lo_running", 32'(bus.i_scroll_running), 32'd1);
    checkOutput("wait_lo_pulses", scrPulses - sPrev, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_ready", 32'(bus.o_ready), 32'd1);
    checkOutput("mid_rst_col", 32'(bus.o_col), 32'd0);
    checkOutput("mid_rst_row", 32'(bus.o_row), 32'd0);
    sPrev = scrPulses;
    cPrev = clrPulses;
    repeat (10) @(negedge clk);
    checkOutput("post_rst_scroll_pulses", scrPulses - sPrev, 32'd0);
    checkOutput("post_rst_clear_pulses", clrPulses - cPrev, 32'd0);

    applyStimulus(8'h42, 1'b1, 1'b1, 11'h000, t);
    waitReady(r);
    checkOutput("post_rst_col", 32'(bus.o_col), 32'd1);

    checkOutput("pending_writes", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tty_ctrl.md
Name: tty_ctrl

Overview:
Teletype sequencer for the text terminal. Accepts one character at a time, interprets control codes, writes printable characters into VRAM at the cursor and advances the cursor. On line overflow it sequences the scroll engine, and on form-feed it sequences the clear engine. While idle it owns the VRAM port; while an engine runs, the engine's running flag hands the port to that engine via the existing mux.

Parameters:
COLS, 60, visible text columns (1..64)
ROWS, 17, visible text rows (1..32)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  character available on i_char
i_char  in  8  character byte
i_ctrl_en  in  1  1 = obey control codes; 0 = every byte is printable
o_ready  out  1  block can accept a character this cycle
o_scroll_start  out  1  one-cycle start pulse to scroll engine
i_scroll_running  in  1  scroll engine busy
o_clear_start  out  1  one-cycle start pulse to clear engine
i_clear_running  in  1  clear engine busy
o_vram_addr  out  11  VRAM address {row[4:0], col[5:0]}
o_vram_din  out  8  VRAM write data
o_vram_ce  out  1  VRAM clock enable
o_vram_w  out  1  VRAM write strobe
o_col  out  6  cursor column
o_row  out  5  cursor row

Behaviour:
- Reset: state IDLE; o_col=0, o_row=0; o_ready=1; o_scroll_start, o_clear_start, o_vram_ce, o_vram_w all 0; o_vram_din=0. Reset mid-operation aborts immediately with no further strobes. Engines are reset by the same i_rst at top level.
- Handshake: a character is accepted on a cycle with i_valid && o_ready. o_ready is 1 only in IDLE. i_char and i_ctrl_en are latched on accept.
- o_vram_addr always equals {o_row, o_col}, so the cursor overlay tracks it.
- FSM states: IDLE, DECODE, WRITE, ADV, SCR_START, SCR_WAIT_HI, SCR_WAIT_LO, CLR_START, CLR_WAIT_HI, CLR_WAIT_LO.
- DECODE, when ctrl enabled:
  - 0x0D CR: col←0, go to IDLE.
  - 0x0A LF: perform newline.
  - 0x08 BS: col←col-1 if col>0; at col=0 no change. No erase.
  - 0x0C FF: go to CLR_START.
  - Any other byte <0x20, or 0x7F: ignored, go to IDLE.
  - All other bytes, and every byte when ctrl is disabled: go to WRITE.
- WRITE: exactly one cycle with o_vram_ce=1, o_vram_w=1, o_vram_din=latched char, at the current cursor address. Then ADV.
- ADV: if col<COLS-1, col←col+1 and go to IDLE. Otherwise col←0 and perform newline.
- Newline:
  - If row<ROWS-1: row←row+1, go to IDLE.
  - Else: row unchanged, go to SCR_START.
- SCR_START: o_scroll_start=1 for exactly one cycle, then SCR_WAIT_HI. Stay there until i_scroll_running=1, then SCR_WAIT_LO. Stay there until i_scroll_running=0, then IDLE.
- CLR_START, CLR_WAIT_HI, CLR_WAIT_LO: same sequence using the clear signals. On entering CLR_START set col←0, row←0.
- Outside WRITE, o_vram_ce and o_vram_w are 0. Idle reads are driven by the owner of the port.
- Latency from accept at cycle T:
  - Printable: write strobe at T+2; o_ready=1 again at T+4 if no scroll.
  - CR, BS, ignored byte: o_ready at T+2.
  - LF without scroll: o_ready at T+2.
- Simultaneous events: when i_scroll_running or i_clear_running is already high in IDLE, o_ready is forced 0 until both are low.
- Wrap case: the last column of the last row writes the character first, then scrolls. The cursor ends at col 0, row ROWS-1.

Test Plan:
- Reset, then 'A'(0x41) with ctrl_en=1 → single write strobe addr 0x000 din 0x41 at T+2; o_col=1, o_row=0; o_ready high at T+4.
- 60 × 'x' from home → 60 writes at addr 0x000..0x03B; cursor ends col 0, row 1; no scroll pulse.
- Cursor at row 16, col 59; send 'Z' → write at {16,59}; one o_scroll_start pulse. Model scroll running 20 cycles → o_ready held 0 until running falls; final cursor (0,16).
- Send 0x0C; model clear running 100 cycles → one o_clear_start pulse; cursor (0,0); no VRAM write; o_ready returns after running falls.
- Sequence CR, BS at col 0, BS at col 5, 0x07 with ctrl_en=1 → col 0, 0, 4, unchanged; zero write strobes. Same 0x07 with ctrl_en=0 → written as a glyph.
- Assert i_rst during SCR_WAIT_LO → next cycle IDLE, cursor (0,0), o_ready=1, no start pulses or write strobes.
